// File: rtl/mac_result_drain.sv
// mac_result_drain: captures the 64-bit MAC accumulator on acc_done, pulses acc_clear,
// then streams the result as two 32-bit words (low first) over valid/ready.
// Optional macro MAC_DRAIN_SAT_EN: single-word mode with unsigned saturation to WORD_W bits.
module mac_result_drain #(
    parameter int WORD_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ACC_W-1:0]  acc_in,
    input  logic              acc_done,
    output logic              acc_clear,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              overrun,
    input  logic              ovr_clr
);
    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

    state_t            state, state_d;
    logic [ACC_W-1:0]  hold, hold_d;
    logic              hs, capture, drop;
    logic              valid_d, last_d;
    logic [WORD_W-1:0] data_d;

    assign hs = out_valid && out_ready;

    // Next state: a new result is taken only when idle or while the final beat is leaving.
    always_comb begin
        state_d = state;
        capture = 1'b0;
        case (state)
            IDLE:    capture = acc_done;
`ifdef MAC_DRAIN_SAT_EN
            SEND_LO: begin
                if (hs) state_d = IDLE;
                capture = acc_done && hs && !acc_clear;
            end
`else
            SEND_LO: if (hs) state_d = SEND_HI;
            SEND_HI: begin
                if (hs) state_d = IDLE;
                capture = acc_done && hs;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (capture) state_d = SEND_LO;
        drop   = acc_done && !capture;
        hold_d = capture ? acc_in : hold;
    end

    // Output values for the next cycle, derived from next state and next hold contents.
    always_comb begin
        valid_d = state_d != IDLE;
`ifdef MAC_DRAIN_SAT_EN
        last_d = valid_d;
        data_d = !valid_d ? '0 : (|hold_d[ACC_W-1:WORD_W]) ? '1 : hold_d[WORD_W-1:0];
`else
        last_d = state_d == SEND_HI;
        data_d = state_d == SEND_HI ? hold_d[ACC_W-1:WORD_W] :
                 state_d == SEND_LO ? hold_d[WORD_W-1:0] : '0;
`endif
    end

    // State, hold register and all outputs are registered; reset aborts any transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hold      <= '0;
            acc_clear <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            hold      <= hold_d;
            acc_clear <= capture;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_last  <= last_d;
            busy      <= valid_d;
            overrun   <= drop || (overrun && !ovr_clr);
        end
    end
endmodule
